// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-stage request controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (inc_i && ~&cnt_q)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage request controller: one access in flight, stalls the pipeline,
// checks alignment, bounds WAIT with a timeout and keeps perf counters.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        stall_out,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        err_sticky,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_hit,
  input  logic        mem_err,
  input  logic [15:0] mem_rdata,
  output logic [15:0] req_cnt,
  output logic [15:0] hit_cnt
);

  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        wr_q, wr_d, err_q, err_d, sticky_q;
  logic [7:0]  tcnt_q, tcnt_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    tcnt_d  = tcnt_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        wr_d    = req_wr;
        rdata_d = '0;
        // odd addresses never reach the memory system
        err_d   = req_addr[0];
        state_d = req_addr[0] ? RESP : ISSUE;
      end
      ISSUE: if (!mem_stall) begin
        mem_rd  = ~wr_q;
        mem_wr  = wr_q;
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_err) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (mem_done) begin
          if (!wr_q) rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          // this cycle is WAIT cycle tcnt_q+1; give up on the TIMEOUT-th one
          if (tcnt_q < TO8) tcnt_d = tcnt_q + 8'd1;
          if (tcnt_q >= TO8 - 8'd1) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      tcnt_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
      sticky_q <= sticky_q | rsp_err;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_err    = rsp_valid & err_q;
  assign rsp_rdata  = rsp_valid ? rdata_q : 16'h0;
  assign err_sticky = sticky_q;
  assign stall_out  = (state_q == ISSUE) | (state_q == WAIT) | ((state_q == IDLE) & req_valid);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  sat_counter #(.W(16)) u_req_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (1'b0),
    .inc_i (rsp_valid & ~err_q),
    .cnt_o (req_cnt)
  );

  sat_counter #(.W(16)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (1'b0),
    .inc_i ((state_q == WAIT) & mem_done & mem_hit),
    .cnt_o (hit_cnt)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench: two controllers (long and short timeout) driven by a cycle-accurate
// transaction model of the memory system; responses predicted from access rules.
module tb_mem_stage_ctrl;

  localparam int TO_A = 16;
  localparam int TO_B = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 0, req_wr = 0;
  logic [15:0] req_addr = 0, req_wdata = 0;
  logic        mem_done = 0, mem_stall = 0, mem_hit = 0, mem_err = 0;
  logic [15:0] mem_rdata = 0;
  logic        sel = 1'b0;

  logic        a_stall, a_rv, a_re, a_es, a_rd, a_wr;
  logic [15:0] a_rdata, a_maddr, a_mwdata, a_rc, a_hc;
  logic        b_stall, b_rv, b_re, b_es, b_rd, b_wr;
  logic [15:0] b_rdata, b_maddr, b_mwdata, b_rc, b_hc;

  logic        o_stall, o_rv, o_re, o_es, o_rd, o_wr;
  logic [15:0] o_rdata, o_maddr, o_mwdata, o_rc, o_hc;

  int vectors = 0, miscompares = 0;
  int m_req[2], m_hit[2];
  bit m_sticky[2];
  int tmo[2];

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(TO_A)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall_out(a_stall),
    .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_re), .err_sticky(a_es),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rd(a_rd), .mem_wr(a_wr),
    .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit),
    .mem_err(mem_err), .mem_rdata(mem_rdata), .req_cnt(a_rc), .hit_cnt(a_hc)
  );

  mem_stage_ctrl #(.TIMEOUT(TO_B)) dut_short (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall_out(b_stall),
    .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_re), .err_sticky(b_es),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rd(b_rd), .mem_wr(b_wr),
    .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit),
    .mem_err(mem_err), .mem_rdata(mem_rdata), .req_cnt(b_rc), .hit_cnt(b_hc)
  );

  assign o_stall  = sel ? b_stall  : a_stall;
  assign o_rv     = sel ? b_rv     : a_rv;
  assign o_re     = sel ? b_re     : a_re;
  assign o_es     = sel ? b_es     : a_es;
  assign o_rd     = sel ? b_rd     : a_rd;
  assign o_wr     = sel ? b_wr     : a_wr;
  assign o_rdata  = sel ? b_rdata  : a_rdata;
  assign o_maddr  = sel ? b_maddr  : a_maddr;
  assign o_mwdata = sel ? b_mwdata : a_mwdata;
  assign o_rc     = sel ? b_rc     : a_rc;
  assign o_hc     = sel ? b_hc     : a_hc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".stall_out"}, o_stall, 0);
    chk({tag, ".rsp_valid"}, o_rv, 0);
    chk({tag, ".rsp_err"},   o_re, 0);
    chk({tag, ".rsp_rdata"}, o_rdata, 0);
    chk({tag, ".mem_rd"},    o_rd, 0);
    chk({tag, ".mem_wr"},    o_wr, 0);
    chk({tag, ".mem_addr"},  o_maddr, 0);
    chk({tag, ".mem_wdata"}, o_mwdata, 0);
    chk({tag, ".err_sticky"}, o_es, 0);
    chk({tag, ".req_cnt"},   o_rc, 0);
    chk({tag, ".hit_cnt"},   o_hc, 0);
  endtask

  // One pipeline request. Memory behaviour: stalled for nstall ISSUE cycles,
  // Done on WAIT cycle ndone (0 = never), optionally with err.
  task automatic txn(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                     input int nstall, input int ndone, input bit merr, input bit hit,
                     input logic [15:0] rdata);
    int s     = sel ? 1 : 0;
    bit mis   = addr[0];
    bit dn_ok = !mis && ndone > 0 && ndone <= tmo[s];
    bit err   = mis || !dn_ok || (dn_ok && merr);
    int fire  = 1 + nstall;
    int dcyc  = 1 + nstall + ndone;
    int lat   = mis ? 1 : (dn_ok ? 2 + nstall + ndone : 2 + nstall + tmo[s]);
    logic [15:0] exp_rd = (!err && !wr) ? rdata : 16'h0;
    for (int c = 0; c <= lat; c++) begin
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
      mem_stall = !mis && c >= 1 && c <= nstall;
      mem_done  = dn_ok && c == dcyc;
      mem_err   = dn_ok && merr && c == dcyc;
      mem_hit   = (dn_ok && c == dcyc) ? hit : 1'($urandom);
      mem_rdata = (dn_ok && c == dcyc) ? rdata : 16'($urandom);
      @(negedge clk);
      chk("rsp_valid", o_rv, c == lat);
      chk("stall_out", o_stall, c < lat);
      chk("mem_rd", o_rd, !mis && !wr && c == fire);
      chk("mem_wr", o_wr, !mis && wr && c == fire);
      if (!mis && c == fire) begin
        chk("mem_addr", o_maddr, addr);
        if (wr) chk("mem_wdata", o_mwdata, wdata);
      end
      if (c == lat) begin
        chk("rsp_err", o_re, err);
        chk("rsp_rdata", o_rdata, exp_rd);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_done = 1'b0; mem_err = 1'b0; mem_stall = 1'b0;
    if (!err && m_req[s] < 65535) m_req[s]++;
    if (dn_ok && hit && m_hit[s] < 65535) m_hit[s]++;
    m_sticky[s] = m_sticky[s] | err;
    @(negedge clk);
    chk("idle.stall_out", o_stall, 0);
    chk("req_cnt", o_rc, m_req[s]);
    chk("hit_cnt", o_hc, m_hit[s]);
    chk("err_sticky", o_es, m_sticky[s]);
    @(posedge clk); #1;
  endtask

  initial begin
    tmo[0] = TO_A; tmo[1] = TO_B;
    for (int i = 0; i < 2; i++) begin m_req[i] = 0; m_hit[i] = 0; m_sticky[i] = 0; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // load hit, store miss, misaligned load, error with done
    txn(0, 16'h0010, 16'h0000, 0, 1, 0, 1, 16'hBEEF);
    txn(1, 16'h0822, 16'h1234, 2, 10, 0, 0, 16'hAAAA);
    txn(0, 16'h0003, 16'h0000, 0, 0, 0, 0, 16'h0000);
    txn(0, 16'h0100, 16'h0000, 0, 2, 1, 1, 16'h5555);
    // done on the very last allowed WAIT cycle still succeeds
    txn(0, 16'h0200, 16'h0000, 1, TO_A, 0, 0, 16'h0F0F);

    // timeout on the short-timeout instance
    sel = 1'b1;
    txn(0, 16'h0400, 16'h0000, 0, 0, 0, 0, 16'h0000);
    txn(0, 16'h0402, 16'h0000, 0, TO_B, 0, 1, 16'hC0DE);
    sel = 1'b0;

    // reset while WAITing
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0040; req_wdata = 16'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin m_req[i] = 0; m_hit[i] = 0; m_sticky[i] = 0; end
    @(negedge clk);
    chk("postreset.rsp_valid", o_rv, 0);
    @(posedge clk); #1;
    txn(0, 16'h0044, 16'h0000, 0, 1, 0, 1, 16'h7777);

    // randomized traffic on the long-timeout instance
    for (int n = 0; n < 40; n++) begin
      bit          wr    = 1'($urandom);
      logic [15:0] addr  = 16'($urandom);
      logic [15:0] wdata = 16'($urandom);
      logic [15:0] rdata = 16'($urandom);
      int          nst   = $urandom_range(0, 3);
      int          nd    = $urandom_range(0, 7);
      bit          me    = ($urandom_range(0, 7) == 0);
      bit          ht    = 1'($urandom);
      if (nd == 7) nd = TO_A + 2;
      if ($urandom_range(0, 2) != 0) addr[0] = 1'b0;
      txn(wr, addr, wdata, nst, nd, me, ht, rdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
